alu_requester: RTL

ALU_REQUESTER -- requirements
Module: alu_requester

---
 rtl/alu_requester.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_requester.sv
// Command/response front end for a combinational ALU: holds operands on the ALU for
// SETTLE edges, then captures the result into a response register.
module alu_requester #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] num1,
   output logic [31:0] num2,
   output logic [5:0]  alu_ctrl,
   input  logic [31:0] res,
   input  logic        zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_res,
   output logic        rsp_zero,
   output logic        rsp_err,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_num1;
   logic [31:0] r_num2;
   logic [5:0]  r_alu_ctrl;
   logic [31:0] r_rsp_res;
   logic        r_rsp_zero;
   logic        r_rsp_err;
   logic [15:0] r_op_count;
   logic        w_legal;
   logic        w_accept;
   logic        w_rsp_hs;

   always_comb begin
      w_legal = 1'b0;
      case (cmd_op)
         6'd4, 6'd5, 6'd6, 6'd9, 6'd10, 6'd11, 6'd12: w_legal = 1'b1;
         default:                                     w_legal = 1'b0;
      endcase
   end

   // Both handshake outputs are gated by rst so nothing is offered during reset.
   assign cmd_ready = (r_state == IDLE) && !rst;
   assign rsp_valid = (r_state == RESP) && !rst;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_rsp_hs  = rsp_valid && rsp_ready;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = w_legal ? DRIVE : RESP;
         DRIVE:   if (r_cnt == '0) w_next_state = RESP;
         RESP:    if (w_rsp_hs) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_num1     <= '0;
         r_num2     <= '0;
         r_alu_ctrl <= '0;
         r_rsp_res  <= '0;
         r_rsp_zero <= 1'b0;
         r_rsp_err  <= 1'b0;
         r_op_count <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_legal) begin
                     r_num1     <= cmd_a;
                     r_num2     <= cmd_b;
                     r_alu_ctrl <= cmd_op;
                     r_cnt      <= 4'(SETTLE - 1);
                  end else begin
                     r_rsp_res  <= '0;
                     r_rsp_zero <= 1'b0;
                     r_rsp_err  <= 1'b1;
                  end
               end
            end
            DRIVE: begin
               if (r_cnt == '0) begin
                  r_rsp_res  <= res;
                  r_rsp_zero <= zero;
                  r_rsp_err  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (w_rsp_hs && !r_rsp_err) r_op_count <= r_op_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign num1     = r_num1;
   assign num2     = r_num2;
   assign alu_ctrl = r_alu_ctrl;
   assign rsp_res  = r_rsp_res;
   assign rsp_zero = r_rsp_zero;
   assign rsp_err  = r_rsp_err;
   assign op_count = r_op_count;

endmodule

// Combinational ALU: 4 AND, 5 OR, 6 XOR, 9 ADD, 10 SUB, 11 signed SLT, 12 NOR.
module alu_module (
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic [5:0]  alu_ctrl,
   output logic [31:0] res,
   output logic        zero
);

   always_comb begin
      res = '0;
      case (alu_ctrl)
         6'd4:    res = num1 & num2;
         6'd5:    res = num1 | num2;
         6'd6:    res = num1 ^ num2;
         6'd9:    res = num1 + num2;
         6'd10:   res = num1 - num2;
         6'd11:   res = {31'd0, $signed(num1) < $signed(num2)};
         6'd12:   res = ~(num1 | num2);
         default: res = '0;
      endcase
   end

   assign zero = (res == '0);

endmodule
